// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11 reader and its downstream temperature filter.
// Holds the filter FSM encoding, the 40-bit frame field offsets, default
// calibration/threshold values and small frame helper functions.
package dht_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StAdjust,
    StConvert,
    StUpdate
  } dht_state_e;

  // LSB positions of the byte fields inside a raw 40-bit frame
  localparam int unsigned HumIntLsb  = 32;
  localparam int unsigned HumDecLsb  = 24;
  localparam int unsigned TempIntLsb = 16;
  localparam int unsigned TempDecLsb = 8;
  localparam int unsigned CsumLsb    = 0;

  localparam int unsigned DefTempOffset  = 7;
  localparam int unsigned DefHotOn       = 22;
  localparam int unsigned DefHotOff      = 20;
  localparam int unsigned DefConfirm     = 3;
  localparam int unsigned DefStaleCycles = 150000000;

  // Checksum byte must equal the byte-wise sum of the four data bytes, mod 256.
  function automatic logic frame_csum_ok(input logic [39:0] f);
    logic [7:0] sum;
    sum = f[HumIntLsb +: 8] + f[HumDecLsb +: 8] + f[TempIntLsb +: 8] + f[TempDecLsb +: 8];
    return sum == f[CsumLsb +: 8];
  endfunction

  // Subtract the calibration offset, floor at 0 and cap at 99 so it fits two digits.
  function automatic logic [6:0] adjust_temp(input logic [7:0] t_raw, input logic [7:0] offset);
    logic [7:0] diff;
    if (t_raw <= offset) begin
      diff = 8'd0;
    end else begin
      diff = t_raw - offset;
    end
    if (diff > 8'd99) begin
      diff = 8'd99;
    end
    return diff[6:0];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to two-digit BCD converter, one bit per cycle.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start_i   - load bin_i and begin an 8-step conversion
//   bin_i     - 7-bit binary value (0..99)
//   done_o    - high in the cycle whose closing edge performs the final shift;
//               tens_o/units_o are valid from the following cycle
//   tens_o    - BCD tens digit
//   units_o   - BCD units digit
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [6:0] bin_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [7:0] sr_q, sr_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [2:0] cnt_q, cnt_d;
  logic       active_q, active_d;
  logic [3:0] tens_adj, units_adj;

  always_comb begin
    sr_d      = sr_q;
    tens_d    = tens_q;
    units_d   = units_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    tens_adj  = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
    units_adj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
    if (start_i) begin
      // Leading zero pads the 7-bit value to a fixed 8-step conversion
      sr_d     = {1'b0, bin_i};
      tens_d   = 4'd0;
      units_d  = 4'd0;
      cnt_d    = 3'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      // Hundreds carry out of the tens digit is dropped: inputs never exceed 99
      {tens_d, units_d, sr_d} = {tens_adj, units_adj, sr_q} << 1;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q     <= '0;
      tens_q   <= '0;
      units_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o  = active_q && (cnt_q == 3'd7);
  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/dht_temp_filter.sv
// Post-processing of raw DHT11 frames: checksum validation, calibration offset,
// BCD conversion for the display, debounced hysteretic "hot" flag and a
// stale-sensor timeout.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   test_enable   - freezes frame acceptance and the stale counter
//   frame_valid   - single-cycle strobe qualifying frame
//   frame         - raw 40-bit frame {hum int, hum dec, temp int, temp dec, csum}
//   busy          - a frame is being processed
//   temp_c        - last good adjusted temperature, binary
//   bcd_tens/units- decimal digits of temp_c
//   hot           - debounced hot flag
//   data_ok       - a good frame has been seen and the data is not stale
//   crc_err       - one-cycle pulse per rejected frame
//   sensor_fault  - no good frame within STALE_CYCLES
module dht_temp_filter
  import dht_pkg::*;
#(
  parameter int unsigned TEMP_OFFSET  = DefTempOffset,
  parameter int unsigned HOT_ON       = DefHotOn,
  parameter int unsigned HOT_OFF      = DefHotOff,
  parameter int unsigned CONFIRM      = DefConfirm,
  parameter int unsigned STALE_CYCLES = DefStaleCycles
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        test_enable,
  input  logic        frame_valid,
  input  logic [39:0] frame,
  output logic        busy,
  output logic [7:0]  temp_c,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_units,
  output logic        hot,
  output logic        data_ok,
  output logic        crc_err,
  output logic        sensor_fault
);

  localparam int unsigned VoteW  = $clog2(CONFIRM + 1);
  localparam int unsigned StaleW = $clog2(STALE_CYCLES + 1);

  localparam logic [6:0]        HotOnC    = 7'(HOT_ON);
  localparam logic [6:0]        HotOffC   = 7'(HOT_OFF);
  localparam logic [7:0]        OffsetC   = 8'(TEMP_OFFSET);
  localparam logic [VoteW-1:0]  VoteLast  = VoteW'(CONFIRM - 1);
  localparam logic [StaleW-1:0] StaleMax  = StaleW'(STALE_CYCLES);

  dht_state_e        state_q, state_d;
  logic [39:0]       frame_q, frame_d;
  logic [6:0]        adj_q, adj_d;
  logic [VoteW-1:0]  vote_q, vote_d;
  logic [StaleW-1:0] stale_q, stale_d;
  logic              busy_q, busy_d;
  logic [7:0]        temp_c_q, temp_c_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        units_q, units_d;
  logic              hot_q, hot_d;
  logic              data_ok_q, data_ok_d;
  logic              crc_err_q, crc_err_d;
  logic              fault_q, fault_d;

  logic       bcd_start;
  logic       bcd_done;
  logic [3:0] bcd_tens_w;
  logic [3:0] bcd_units_w;
  logic       vote_agree;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (bcd_start),
    .bin_i   (adj_d),
    .done_o  (bcd_done),
    .tens_o  (bcd_tens_w),
    .units_o (bcd_units_w)
  );

  // A frame votes to toggle only when it argues against the current state
  assign vote_agree = ((adj_q >= HotOnC) && !hot_q) || ((adj_q <= HotOffC) && hot_q);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    adj_d     = adj_q;
    vote_d    = vote_q;
    stale_d   = stale_q;
    temp_c_d  = temp_c_q;
    tens_d    = tens_q;
    units_d   = units_q;
    hot_d     = hot_q;
    data_ok_d = data_ok_q;
    fault_d   = fault_q;
    crc_err_d = 1'b0;
    bcd_start = 1'b0;

    if (!test_enable && (stale_q != StaleMax)) begin
      stale_d = stale_q + StaleW'(1);
    end
    if (stale_d == StaleMax) begin
      fault_d   = 1'b1;
      data_ok_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_valid && !test_enable) begin
          frame_d = frame;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (frame_csum_ok(frame_q)) begin
          state_d = StAdjust;
        end else begin
          crc_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StAdjust: begin
        adj_d     = adjust_temp(frame_q[TempIntLsb +: 8], OffsetC);
        bcd_start = 1'b1;
        state_d   = StConvert;
      end
      StConvert: begin
        if (bcd_done) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        temp_c_d  = {1'b0, adj_q};
        tens_d    = bcd_tens_w;
        units_d   = bcd_units_w;
        data_ok_d = 1'b1;
        // Overrides a timeout landing in the same cycle
        fault_d   = 1'b0;
        stale_d   = '0;
        if (vote_agree) begin
          if (vote_q == VoteLast) begin
            hot_d  = !hot_q;
            vote_d = '0;
          end else begin
            vote_d = vote_q + VoteW'(1);
          end
        end else begin
          vote_d = '0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      adj_q     <= '0;
      vote_q    <= '0;
      stale_q   <= '0;
      busy_q    <= 1'b0;
      temp_c_q  <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      hot_q     <= 1'b0;
      data_ok_q <= 1'b0;
      crc_err_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      adj_q     <= adj_d;
      vote_q    <= vote_d;
      stale_q   <= stale_d;
      busy_q    <= busy_d;
      temp_c_q  <= temp_c_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      hot_q     <= hot_d;
      data_ok_q <= data_ok_d;
      crc_err_q <= crc_err_d;
      fault_q   <= fault_d;
    end
  end

  assign busy         = busy_q;
  assign temp_c       = temp_c_q;
  assign bcd_tens     = tens_q;
  assign bcd_units    = units_q;
  assign hot          = hot_q;
  assign data_ok      = data_ok_q;
  assign crc_err      = crc_err_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_dht_temp_filter.sv
// Bench for dht_temp_filter: directed scenarios plus randomized frames, all
// checked against an arithmetic model of the filter kept in this file.
module tb_dht_temp_filter;

  localparam int Stale = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_enable = 1'b0;
  logic        frame_valid = 1'b0;
  logic [39:0] frame = '0;
  logic        busy;
  logic [7:0]  temp_c;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_units;
  logic        hot;
  logic        data_ok;
  logic        crc_err;
  logic        sensor_fault;

  dht_temp_filter #(
    .STALE_CYCLES (Stale)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .test_enable  (test_enable),
    .frame_valid  (frame_valid),
    .frame        (frame),
    .busy         (busy),
    .temp_c       (temp_c),
    .bcd_tens     (bcd_tens),
    .bcd_units    (bcd_units),
    .hot          (hot),
    .data_ok      (data_ok),
    .crc_err      (crc_err),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state
  int m_temp, m_hot, m_vote, m_data_ok, m_fault, m_stale;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_temp = 0; m_hot = 0; m_vote = 0; m_data_ok = 0; m_fault = 0; m_stale = 0;
  endtask

  task automatic check_all(input string tag, input int crc_exp);
    check({tag, ":temp_c"}, temp_c, m_temp);
    check({tag, ":tens"}, bcd_tens, m_temp / 10);
    check({tag, ":units"}, bcd_units, m_temp % 10);
    check({tag, ":hot"}, hot, m_hot);
    check({tag, ":data_ok"}, data_ok, m_data_ok);
    check({tag, ":fault"}, sensor_fault, m_fault);
    check({tag, ":crc_err"}, crc_err, crc_exp);
    check({tag, ":busy"}, busy, 0);
  endtask

  // Advance n clock edges, tracking the idle-time budget; ends 1 time unit after the edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!test_enable && m_stale < Stale) m_stale++;
      if (m_stale == Stale) begin
        m_fault = 1;
        m_data_ok = 0;
      end
    end
    #1;
  endtask

  function automatic logic [39:0] mk(input int t, input bit good);
    logic [7:0] h, hd, td, cs;
    int s;
    h  = 8'($urandom_range(20, 90));
    hd = 8'($urandom_range(0, 9));
    td = 8'($urandom_range(0, 9));
    s  = int'(h) + int'(hd) + t + int'(td);
    cs = 8'(s % 256);
    if (!good) cs = cs ^ 8'($urandom_range(1, 255));
    return {h, hd, 8'(t), td, cs};
  endfunction

  task automatic apply_frame(input logic [39:0] f, input bit poke);
    int s, t, adj;
    bit good;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    good = ((s % 256) == int'(f[7:0]));
    t = int'(f[23:16]);
    frame = f;
    frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
    check("busy_accept", busy, 1);
    if (!good) begin
      tick(1);
      check("crc_pulse", crc_err, 1);
      check("busy_bad", busy, 0);
      tick(1);
      check_all("after_bad", 0);
    end else begin
      tick(3);
      if (poke) begin
        frame = {32'($urandom), 8'($urandom)};
        frame_valid = 1'b1;
      end
      tick(1);
      frame_valid = 1'b0;
      tick(6);
      check("busy_edge10", busy, 1);
      check("temp_hold", temp_c, m_temp);
      tick(1);
      adj = (t <= 7) ? 0 : t - 7;
      if (adj > 99) adj = 99;
      m_temp = adj;
      m_stale = 0;
      m_fault = 0;
      m_data_ok = 1;
      if ((adj >= 22 && m_hot == 0) || (adj <= 20 && m_hot == 1)) begin
        m_vote++;
        if (m_vote == 3) begin
          m_hot = 1 - m_hot;
          m_vote = 0;
        end
      end else begin
        m_vote = 0;
      end
      check_all("after_good", 0);
    end
  endtask

  initial begin
    logic [39:0] f_good, f_bad;
    int t;
    f_good = 40'h37_00_1F_00_56;
    f_bad  = 40'h37_00_1F_00_55;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0);
    rst = 1'b0;

    // Nominal frame, three times: hot only after the third
    apply_frame(f_good, 1'b0);
    check("first_temp", temp_c, 24);
    check("first_tens", bcd_tens, 2);
    check("first_units", bcd_units, 4);
    check("hot_after_1", hot, 0);
    apply_frame(f_good, 1'b0);
    check("hot_after_2", hot, 0);
    apply_frame(f_good, 1'b1);
    check("hot_after_3", hot, 1);

    // Hysteresis band: adj 21 holds hot
    repeat (3) apply_frame(mk(28, 1'b1), 1'b0);
    check("hyst_21_hold", hot, 1);
    repeat (3) apply_frame(mk(27, 1'b1), 1'b0);
    check("hyst_20_clear", hot, 0);
    repeat (3) apply_frame(mk(31, 1'b1), 1'b0);
    check("reheat", hot, 1);
    apply_frame(mk(27, 1'b1), 1'b0);
    apply_frame(mk(27, 1'b1), 1'b0);
    apply_frame(mk(28, 1'b1), 1'b0);
    apply_frame(mk(27, 1'b1), 1'b0);
    check("hyst_break", hot, 1);

    // Bad frame leaves the vote count untouched
    apply_frame(mk(27, 1'b1), 1'b0);
    apply_frame(mk(27, 1'b1), 1'b0);
    apply_frame(f_bad, 1'b0);
    check("bad_keeps_temp", temp_c, 20);
    apply_frame(mk(27, 1'b1), 1'b0);
    check("bad_keeps_vote", hot, 0);

    // Saturation
    apply_frame(mk(5, 1'b1), 1'b0);
    check("sat_low", temp_c, 0);
    apply_frame(mk(120, 1'b1), 1'b0);
    check("sat_high", temp_c, 99);
    check("sat_high_digits", {bcd_tens, bcd_units}, 8'h99);

    // Reset in the middle of conversion
    frame = mk(30, 1'b1);
    frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid", 0);
    rst = 1'b0;
    tick(1);
    apply_frame(mk(30, 1'b1), 1'b0);
    check("post_rst_temp", temp_c, 23);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 130)) : int'($urandom_range(25, 31));
      apply_frame(mk(t, $urandom_range(0, 3) != 0), $urandom_range(0, 3) == 0);
      tick($urandom_range(0, 15));
      check_all("gap", 0);
    end

    // Stale timeout boundary
    apply_frame(mk(30, 1'b1), 1'b0);
    tick(Stale - 1);
    check("stale_99", sensor_fault, 0);
    tick(1);
    check("stale_100", sensor_fault, 1);
    check("stale_data_ok", data_ok, 0);
    check_all("stale", 0);

    // Frozen: no timeout, no frame acceptance
    apply_frame(mk(26, 1'b1), 1'b0);
    test_enable = 1'b1;
    tick(200);
    check("frozen_fault", sensor_fault, 0);
    frame = mk(60, 1'b1);
    frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
    check("frozen_busy", busy, 0);
    tick(12);
    check_all("frozen", 0);
    test_enable = 1'b0;
    tick(Stale - 1);
    check_all("unfreeze_99", 0);
    tick(1);
    check("unfreeze_fault", sensor_fault, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dht_temp_filter.md
# dht_temp_filter

Downstream consumer of the DHT11 reader: takes each raw 40-bit sensor frame, verifies its checksum, applies the calibration offset and converts the temperature to two BCD digits for the 7-segment display. It also derives a debounced, hysteretic "too hot" stimulus for the Tamagotchi state logic. It flags sensor loss when no good frame arrives within a timeout.

## Interface
- TEMP_OFFSET, 7: degrees subtracted from the raw temperature integer byte.
- HOT_ON, 22: adjusted temperature at or above which a frame votes "hot".
- HOT_OFF, 20: adjusted temperature at or below which a frame votes "cool"; must be < HOT_ON.
- CONFIRM, 3: consecutive agreeing good frames required to toggle `hot`.
- STALE_CYCLES, 150000000: clk cycles (3 s at 50 MHz) without a good frame before `sensor_fault` asserts.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- test_enable  in  1  when 1, the block is frozen: frames are ignored, the stale counter holds and outputs hold.
- frame_valid  in  1  single-cycle strobe; `frame` is valid in the same cycle.
- frame  in  40  bit layout: [39:32] hum int, [31:24] hum dec, [23:16] temp int, [15:8] temp dec, [7:0] checksum.
- busy  out  1  high while a frame is being processed.
- temp_c  out  8  last good adjusted temperature, binary.
- bcd_tens  out  4  tens digit of temp_c.
- bcd_units  out  4  units digit of temp_c.
- hot  out  1  debounced hot flag, active-high.
- data_ok  out  1  at least one good frame received and not stale.
- crc_err  out  1  one-cycle pulse per rejected frame.
- sensor_fault  out  1  stale timeout reached.

## Operation
- All outputs reset to 0. The FSM resets to IDLE; the vote counter and the stale counter reset to 0.
- FSM states: IDLE, CHECK, ADJUST, CONVERT, UPDATE.
- IDLE -> CHECK on `frame_valid` && !`test_enable`. The frame is latched on that edge, and `busy` rises on the same edge.
- `frame_valid` while `busy` is dropped silently; no queueing.
- CHECK: sum = (hum int + hum dec + temp int + temp dec) mod 256.
  - Mismatch against the checksum byte: pulse `crc_err` for 1 cycle, go to IDLE. All other outputs and the vote counter are unchanged.
  - Match: go to ADJUST.
- ADJUST: adj = temp int − TEMP_OFFSET, saturating at 0, then clamped to 99. Go to CONVERT.
- CONVERT: sequential shift-add-3 conversion, exactly 8 cycles (one bit per cycle). Then go to UPDATE.
- UPDATE: register `temp_c`, `bcd_tens` and `bcd_units`. Set `data_ok` = 1, clear `sensor_fault`, zero the stale counter, apply the vote. Go to IDLE.
- Vote rules:
  - If adj ≥ HOT_ON and `hot` = 0: increment the vote counter.
  - If adj ≤ HOT_OFF and `hot` = 1: increment the vote counter.
  - Otherwise: clear the vote counter.
  - When the vote counter reaches CONFIRM: toggle `hot` and clear the vote counter.
- Stale counter: increments every cycle when !`test_enable` and saturates. On reaching STALE_CYCLES, set `sensor_fault` = 1 and `data_ok` = 0. `hot`, `temp_c` and the digits hold their last values.
- `test_enable` asserted mid-frame: the FSM completes the current frame normally; only new frame acceptance and the stale counter freeze.
- Stale timeout in the same cycle as UPDATE: UPDATE wins (`sensor_fault` ends the cycle at 0).
- `rst` mid-frame: immediate return to IDLE with all reset values; the partial frame is discarded.

## Timing
- Good frame, measured from the `frame_valid` edge: CHECK +1, ADJUST +2, CONVERT +3..+10, UPDATE +11.
- Outputs are visible on the cycle after edge +11, i.e. 11-cycle latency.
- `busy` is high for 11 cycles on a good frame.
- Bad frame: `crc_err` is high for the 1 cycle after CHECK; `busy` is high for 1 cycle.
- Maximum accepted frame rate is one per 12 cycles. The DHT11 delivers about one per 0.5 s, so this is never a limit.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `dht_pkg`:
  - FSM state encoding.
  - Frame field bit offsets.
  - Default TEMP_OFFSET, HOT_ON, HOT_OFF and CONFIRM values, also reused by the reader.
- One sub-module `bin2bcd_seq`:
  - Inputs: 7-bit binary, start.
  - Outputs: done after 8 cycles, tens, units.
- The FSM, vote counter and stale counter are in the top module.

## Test plan
- Reset: assert `rst` mid-CONVERT -> all outputs 0 and `busy` = 0 in the same cycle; the next good frame is processed normally.
- Good frame 0x37_00_1F_00_56 (temp 31) -> at +11: `temp_c` = 24, `bcd_tens` = 2, `bcd_units` = 4, `data_ok` = 1. `hot` = 0 after 1 and 2 frames, `hot` = 1 after the 3rd.
- Checksum 0x55 instead of 0x56 -> `crc_err` is a 1-cycle pulse, outputs and vote count unchanged, `busy` high for 1 cycle.
- Hysteresis, starting with `hot` = 1:
  - temp int 28 (adj 21), three frames -> `hot` stays 1 and the vote counter stays 0.
  - temp int 27 (adj 20), three frames -> `hot` = 0.
  - Sequence adj 20, 20, 21, 20 -> `hot` stays 1.
- Saturation:
  - temp int 5 -> `temp_c` = 0, digits 0/0.
  - temp int 120 -> `temp_c` = 99, digits 9/9.
- Stale, with STALE_CYCLES = 100 and `test_enable` = 0:
  - 100 idle cycles after a good frame -> `sensor_fault` = 1, `data_ok` = 0.
  - With `test_enable` = 1 for 200 cycles -> no fault.
  - A `frame_valid` while `busy` -> ignored.
